// File: rtl/dispatch_busytable_if.sv
// -----------------------------------------------------------------------------
// dispatch_busytable_if
//
// Purpose
//   One renamed-instruction channel with a valid/ready handshake. The same
//   interface type carries both the rename -> dispatch offer and the
//   dispatch -> issue-queue enqueue, so the fields line up one to one.
//
// Signals
//   valid        producer offers an instruction
//   ready        consumer accepts this cycle
//   prs1/prs2    physical source registers
//   prd          physical destination register
//   src1/2_is_reg  source is a register (otherwise imm/pc)
//   need_to_wb   instruction writes prd
//   robidx_flag  rob wrap flag
//   robidx       rob index
//   payload      opaque decoded fields, passed through unchanged
//   src1/2_state 1 = source still busy (only meaningful on the IQ side)
//
// Modports
//   master  drives valid and all fields, samples ready
//   slave   samples valid and the rename fields, drives ready
//           (the busy state is produced by dispatch, so the slave omits it)
// -----------------------------------------------------------------------------
interface dispatch_busytable_if #(
    parameter int PREG_W    = 6,
    parameter int ROB_LOG   = 6,
    parameter int PAYLOAD_W = 256
);
    logic                 valid;
    logic                 ready;
    logic [PREG_W-1:0]    prs1;
    logic [PREG_W-1:0]    prs2;
    logic [PREG_W-1:0]    prd;
    logic                 src1_is_reg;
    logic                 src2_is_reg;
    logic                 need_to_wb;
    logic                 robidx_flag;
    logic [ROB_LOG-1:0]   robidx;
    logic [PAYLOAD_W-1:0] payload;
    logic                 src1_state;
    logic                 src2_state;

    modport master (
        output valid, prs1, prs2, prd, src1_is_reg, src2_is_reg, need_to_wb,
               robidx_flag, robidx, payload, src1_state, src2_state,
        input  ready
    );

    modport slave (
        input  valid, prs1, prs2, prd, src1_is_reg, src2_is_reg, need_to_wb,
               robidx_flag, robidx, payload,
        output ready
    );
endinterface

// File: rtl/dispatch_busytable.sv
// -----------------------------------------------------------------------------
// dispatch_busytable
//
// Purpose
//   Dispatch stage between rename and the in-order issue queue. Accepts one
//   renamed instruction per cycle, looks up source readiness in a physical
//   register busy table and presents the instruction to the IQ through a
//   one-entry registered output stage (full throughput with disp.ready=1).
//
//   The busy table is set when a writing instruction is captured and cleared
//   by the two writeback ports, which are the same events that wake the IQ.
//   Every lookup is bypassed against same-cycle writebacks and against the
//   producer currently sitting in the output stage, and a held entry keeps
//   watching writeback, so the state handed to the IQ never misses a wakeup.
//
// Ports
//   clock, reset_n        clock, asynchronous active-low reset
//   rn   (slave)          rename offer; rn.ready = ~flush & (~held | disp.ready)
//   disp (master)         IQ enqueue; registered copy of rn plus src states
//   wb0_*, wb1_*          writeback ports (valid, need_to_wb, prd)
//   flush_valid           redirect flush: squashes the held entry, blocks accept
//   perf_disp_cnt         (DISPATCH_PERF_CNT_EN) count of disp.valid & disp.ready
//   perf_iq_stall_cnt     (DISPATCH_PERF_CNT_EN) count of disp.valid & ~disp.ready
//
// Configuration
//   DISPATCH_PERF_CNT_EN  define to add the two 32-bit wrapping performance
//                         counters; they reset to 0 and ignore flush.
// -----------------------------------------------------------------------------
module dispatch_busytable #(
    parameter int PREG_W    = 6,
    parameter int ROB_LOG   = 6,
    parameter int PAYLOAD_W = 256
) (
    input  logic                  clock,
    input  logic                  reset_n,

    dispatch_busytable_if.slave   rn,
    dispatch_busytable_if.master  disp,

    input  logic                  wb0_valid,
    input  logic                  wb0_need_to_wb,
    input  logic [PREG_W-1:0]     wb0_prd,
    input  logic                  wb1_valid,
    input  logic                  wb1_need_to_wb,
    input  logic [PREG_W-1:0]     wb1_prd,

    input  logic                  flush_valid
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_disp_cnt,
    output logic [31:0]           perf_iq_stall_cnt
`endif
);

    localparam int NUM_PREG = 1 << PREG_W;

    // Everything the output stage holds for one instruction.
    typedef struct packed {
        logic [PREG_W-1:0]    prs1;
        logic [PREG_W-1:0]    prs2;
        logic [PREG_W-1:0]    prd;
        logic                 src1_is_reg;
        logic                 src2_is_reg;
        logic                 need_to_wb;
        logic                 robidx_flag;
        logic [ROB_LOG-1:0]   robidx;
        logic [PAYLOAD_W-1:0] payload;
        logic                 src1_state;
        logic                 src2_state;
    } entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_PREG-1:0] busy_q;
    logic [NUM_PREG-1:0] busy_d;
    logic                disp_valid_q;
    logic                disp_valid_d;
    entry_t              entry_q;
    entry_t              entry_d;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic accept;
    logic held;

    assign rn.ready = ~flush_valid & (~disp_valid_q | disp.ready);
    assign accept   = rn.valid & rn.ready;
    assign held     = disp_valid_q & ~disp.ready;

    // -------------------------------------------------------------------------
    // Busy table update masks
    // -------------------------------------------------------------------------
    // wb_clr doubles as the wb_hit() decode for every lookup below. Bit 0 is
    // forced low so preg 0 can never be woken or set.
    logic [NUM_PREG-1:0] wb_clr;
    logic [NUM_PREG-1:0] busy_set;

    // NOTE: every variable assigned in an always_comb gets a full default at
    // the top of the block, so no path can leave it unassigned (no latch).
    always_comb begin
        wb_clr = '0;
        if (wb0_valid & wb0_need_to_wb) wb_clr[wb0_prd] = 1'b1;
        if (wb1_valid & wb1_need_to_wb) wb_clr[wb1_prd] = 1'b1;
        wb_clr[0] = 1'b0;

        busy_set = '0;
        if (accept & rn.need_to_wb) busy_set[rn.prd] = 1'b1;
        busy_set[0] = 1'b0;

        // Set is OR-ed in last so a same-cycle set and clear on one preg
        // leaves it busy (the new producer owns it).
        busy_d = (busy_q & ~wb_clr) | busy_set;
    end

    // -------------------------------------------------------------------------
    // Source readiness lookup for the instruction being captured
    // -------------------------------------------------------------------------
    // When the held entry is a producer, the consumer behind it sees that preg
    // as busy regardless of the table: the producer's set is the value in
    // flight. A same-cycle writeback still overrides it.
    logic producer_fwd;
    logic src1_busy;
    logic src2_busy;
    logic src1_state_new;
    logic src2_state_new;

    assign producer_fwd = disp_valid_q & entry_q.need_to_wb;

    assign src1_busy = busy_q[rn.prs1] | (producer_fwd & (rn.prs1 == entry_q.prd));
    assign src2_busy = busy_q[rn.prs2] | (producer_fwd & (rn.prs2 == entry_q.prd));

    assign src1_state_new = rn.src1_is_reg & (rn.prs1 != '0) & src1_busy
                          & ~wb_clr[rn.prs1];
    assign src2_state_new = rn.src2_is_reg & (rn.prs2 != '0) & src2_busy
                          & ~wb_clr[rn.prs2];

    // -------------------------------------------------------------------------
    // Output stage next state
    // -------------------------------------------------------------------------
    always_comb begin
        entry_d      = entry_q;
        disp_valid_d = disp_valid_q;

        if (accept) begin
            entry_d.prs1        = rn.prs1;
            entry_d.prs2        = rn.prs2;
            entry_d.prd         = rn.prd;
            entry_d.src1_is_reg = rn.src1_is_reg;
            entry_d.src2_is_reg = rn.src2_is_reg;
            entry_d.need_to_wb  = rn.need_to_wb;
            entry_d.robidx_flag = rn.robidx_flag;
            entry_d.robidx      = rn.robidx;
            entry_d.payload     = rn.payload;
            entry_d.src1_state  = src1_state_new;
            entry_d.src2_state  = src2_state_new;
        end else if (held) begin
            // Waiting on the IQ: keep snooping writeback so the wakeup that
            // arrives meanwhile is not lost before enqueue.
            entry_d.src1_state = entry_q.src1_state & ~wb_clr[entry_q.prs1];
            entry_d.src2_state = entry_q.src2_state & ~wb_clr[entry_q.prs2];
        end

        // Flush dominates both a new accept (already blocked via rn.ready)
        // and an IQ handshake on the held entry.
        if (flush_valid) begin
            disp_valid_d = 1'b0;
        end else if (accept) begin
            disp_valid_d = 1'b1;
        end else if (disp.ready) begin
            disp_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q       <= '0;
            disp_valid_q <= 1'b0;
            entry_q      <= '0;
        end else begin
            busy_q       <= busy_d;
            disp_valid_q <= disp_valid_d;
            entry_q      <= entry_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign disp.valid       = disp_valid_q;
    assign disp.prs1        = entry_q.prs1;
    assign disp.prs2        = entry_q.prs2;
    assign disp.prd         = entry_q.prd;
    assign disp.src1_is_reg = entry_q.src1_is_reg;
    assign disp.src2_is_reg = entry_q.src2_is_reg;
    assign disp.need_to_wb  = entry_q.need_to_wb;
    assign disp.robidx_flag = entry_q.robidx_flag;
    assign disp.robidx      = entry_q.robidx;
    assign disp.payload     = entry_q.payload;
    assign disp.src1_state  = entry_q.src1_state;
    assign disp.src2_state  = entry_q.src2_state;

`ifdef DISPATCH_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32, unaffected by flush)
    // -------------------------------------------------------------------------
    logic [31:0] perf_disp_cnt_q;
    logic [31:0] perf_disp_cnt_d;
    logic [31:0] perf_iq_stall_cnt_q;
    logic [31:0] perf_iq_stall_cnt_d;

    always_comb begin
        perf_disp_cnt_d     = perf_disp_cnt_q     + {31'd0, disp_valid_q & disp.ready};
        perf_iq_stall_cnt_d = perf_iq_stall_cnt_q + {31'd0, held};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_disp_cnt_q     <= '0;
            perf_iq_stall_cnt_q <= '0;
        end else begin
            perf_disp_cnt_q     <= perf_disp_cnt_d;
            perf_iq_stall_cnt_q <= perf_iq_stall_cnt_d;
        end
    end

    assign perf_disp_cnt     = perf_disp_cnt_q;
    assign perf_iq_stall_cnt = perf_iq_stall_cnt_q;
`endif

endmodule
